// File: rtl/varredura_botoes.sv
// -----------------------------------------------------------------------------
// varredura_botoes
// Scans a 4-row x 2-column active-low keypad, debounces each of the 8 keys
// and emits a single-cycle pulse on every debounced press.
//
// Ports
//   clk              in   1  clock
//   rst              in   1  synchronous, active-high reset
//   colunas_teclado  in   2  column sense lines, active-low (0 = pressed)
//   linhas_teclado   out  4  row drive, one-hot active-low
//   botoes           out  8  one-cycle press pulse per key (k = 2*row + col)
//   estado_botoes    out  8  debounced key level (1 = pressed)
// -----------------------------------------------------------------------------
module varredura_botoes #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] colunas_teclado,
    output logic [3:0] linhas_teclado,
    output logic [7:0] botoes,
    output logic [7:0] estado_botoes
);

    localparam int             DW         = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_DIV - 1);
    // Counter value at which the next differing sample completes the debounce.
    localparam logic [3:0]     DB_LAST    = 4'(DEBOUNCE_SCANS - 1);

    logic [DW-1:0]     dwell_q, dwell_d;
    logic [1:0]        row_q, row_d;
    logic [7:0][3:0]   cnt_q, cnt_d;
    logic [7:0]        estado_q, estado_d;
    logic [7:0]        botoes_q, botoes_d;
    logic              sample;
    logic              raw;

    // Columns are only read on the last dwell cycle of a row, giving the
    // lines a full dwell period to settle after the row drive changes.
    assign sample = (dwell_q == DWELL_LAST);

    always_comb begin
        dwell_d  = sample ? '0 : dwell_q + 1'b1;
        row_d    = sample ? row_q + 2'd1 : row_q;
        cnt_d    = cnt_q;
        estado_d = estado_q;
        botoes_d = '0;
        raw      = 1'b0;
        if (sample) begin
            for (int k = 0; k < 8; k++) begin
                if (2'(k / 2) == row_q) begin
                    raw = ~colunas_teclado[k % 2];
                    if (raw == estado_q[k]) begin
                        cnt_d[k] = 4'd0;
                    end else if (cnt_q[k] == DB_LAST) begin
                        estado_d[k] = raw;
                        cnt_d[k]    = 4'd0;
                        // Pulse only on the 0->1 transition; releases are silent.
                        botoes_d[k] = raw;
                    end else begin
                        cnt_d[k] = cnt_q[k] + 4'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dwell_q  <= '0;
            row_q    <= 2'd0;
            cnt_q    <= '0;
            estado_q <= '0;
            botoes_q <= '0;
        end else begin
            dwell_q  <= dwell_d;
            row_q    <= row_d;
            cnt_q    <= cnt_d;
            estado_q <= estado_d;
            botoes_q <= botoes_d;
        end
    end

    assign linhas_teclado = ~(4'b0001 << row_q);
    assign botoes         = botoes_q;
    assign estado_botoes  = estado_q;

endmodule

// File: tb/tb_varredura_botoes.sv
// Directed bench for varredura_botoes with SCAN_DIV=4, DEBOUNCE_SCANS=3.
// A behavioural keypad drives the column lines from the 'keys' vector and
// the row currently driven. After reset release, row r is sampled on edge
// e = 4*(r+1) + 16*n (e counted from the first edge with rst low).
module tb_varredura_botoes;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] colunas_teclado;
    logic [3:0] linhas_teclado;
    logic [7:0] botoes;
    logic [7:0] estado_botoes;

    logic [7:0] keys = 8'h00;
    int         e;
    logic [7:0] bot_or;
    int         checks = 0;
    int         failures = 0;

    varredura_botoes #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
        .clk             (clk),
        .rst             (rst),
        .colunas_teclado (colunas_teclado),
        .linhas_teclado  (linhas_teclado),
        .botoes          (botoes),
        .estado_botoes   (estado_botoes)
    );

    always #5 clk = ~clk;

    // Keypad model: a pressed key in the driven row pulls its column low.
    always_comb begin
        colunas_teclado = 2'b11;
        case (linhas_teclado)
            4'b1110: colunas_teclado = ~keys[1:0];
            4'b1101: colunas_teclado = ~keys[3:2];
            4'b1011: colunas_teclado = ~keys[5:4];
            4'b0111: colunas_teclado = ~keys[7:6];
            default: colunas_teclado = 2'b11;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
        e++;
        bot_or |= botoes;
    endtask

    task automatic run_until(input int target);
        while (e < target) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        e      = 0;
        bot_or = 8'h00;
    endtask

    task automatic test_reset();
        keys = 8'h00;
        do_reset();
        checks++;
        if (linhas_teclado !== 4'b1110) begin
            failures++;
            $display("FAIL reset_linhas got=%b exp=1110", linhas_teclado);
        end
        checks++;
        if (botoes !== 8'h00 || estado_botoes !== 8'h00) begin
            failures++;
            $display("FAIL reset_outputs botoes=%h estado=%h exp=00/00", botoes, estado_botoes);
        end
    endtask

    task automatic test_scan();
        logic [3:0] exp_l;
        keys = 8'h00;
        do_reset();
        for (int i = 0; i < 34; i++) begin
            tick();
            case ((e / 4) % 4)
                0: exp_l = 4'b1110;
                1: exp_l = 4'b1101;
                2: exp_l = 4'b1011;
                default: exp_l = 4'b0111;
            endcase
            checks++;
            if (linhas_teclado !== exp_l) begin
                failures++;
                $display("FAIL scan_linhas e=%0d got=%b exp=%b", e, linhas_teclado, exp_l);
            end
            checks++;
            if (botoes !== 8'h00 || estado_botoes !== 8'h00) begin
                failures++;
                $display("FAIL scan_idle e=%0d botoes=%h estado=%h exp=00/00", e, botoes, estado_botoes);
            end
        end
    endtask

    // Key 5 held from before the first row-2 sample: samples at 12, 28, 44.
    task automatic test_hold_and_release();
        keys = 8'h20;
        do_reset();
        run_until(43);
        checks++;
        if (estado_botoes !== 8'h00 || bot_or !== 8'h00) begin
            failures++;
            $display("FAIL k5_early estado=%h bot_or=%h exp=00/00", estado_botoes, bot_or);
        end
        tick();
        checks++;
        if (botoes !== 8'h20 || estado_botoes !== 8'h20) begin
            failures++;
            $display("FAIL k5_pulse botoes=%h estado=%h exp=20/20", botoes, estado_botoes);
        end
        bot_or = 8'h00;
        run_until(100);
        checks++;
        if (bot_or !== 8'h00 || estado_botoes !== 8'h20) begin
            failures++;
            $display("FAIL k5_held bot_or=%h estado=%h exp=00/20", bot_or, estado_botoes);
        end
        // Release: next row-2 samples at 108, 124, 140.
        keys = 8'h00;
        run_until(139);
        checks++;
        if (estado_botoes !== 8'h20) begin
            failures++;
            $display("FAIL k5_rel_early estado=%h exp=20", estado_botoes);
        end
        tick();
        checks++;
        if (estado_botoes !== 8'h00) begin
            failures++;
            $display("FAIL k5_released estado=%h exp=00", estado_botoes);
        end
        run_until(150);
        checks++;
        if (bot_or !== 8'h00) begin
            failures++;
            $display("FAIL k5_rel_pulse bot_or=%h exp=00", bot_or);
        end
    endtask

    // Key 0 bounce across row-0 samples (edges 4, 20, 36, 52, 68, 84).
    task automatic test_bounce();
        logic [5:0] pat;
        pat  = 6'b111011;
        keys = 8'h00;
        do_reset();
        for (int j = 0; j < 6; j++) begin
            run_until(3 + 16 * j);
            keys[0] = pat[j];
            tick();
        end
        checks++;
        if (botoes !== 8'h01 || estado_botoes !== 8'h01) begin
            failures++;
            $display("FAIL bounce_pulse botoes=%h estado=%h exp=01/01", botoes, estado_botoes);
        end
        checks++;
        if ((bot_or & ~8'h01) !== 8'h00) begin
            failures++;
            $display("FAIL bounce_stray bot_or=%h exp=01", bot_or);
        end
        // Any pulse before the sixth sample would show up one edge earlier.
        bot_or = 8'h00;
        tick();
        checks++;
        if (botoes !== 8'h00) begin
            failures++;
            $display("FAIL bounce_width botoes=%h exp=00", botoes);
        end
    endtask

    task automatic test_bounce_early();
        // Same pattern, but check nothing was debounced just before sample 6.
        logic [5:0] pat;
        pat  = 6'b111011;
        keys = 8'h00;
        do_reset();
        for (int j = 0; j < 5; j++) begin
            run_until(3 + 16 * j);
            keys[0] = pat[j];
            tick();
        end
        keys[0] = 1'b1;
        run_until(83);
        checks++;
        if (bot_or !== 8'h00 || estado_botoes !== 8'h00) begin
            failures++;
            $display("FAIL bounce_early bot_or=%h estado=%h exp=00/00", bot_or, estado_botoes);
        end
    endtask

    task automatic test_back_to_back();
        // Keys 6 and 7: row-3 samples at 16, 32, 48.
        keys = 8'hC0;
        do_reset();
        run_until(47);
        checks++;
        if (bot_or !== 8'h00) begin
            failures++;
            $display("FAIL same_row_early bot_or=%h exp=00", bot_or);
        end
        tick();
        checks++;
        if (botoes !== 8'hC0) begin
            failures++;
            $display("FAIL same_row_pulse botoes=%h exp=c0", botoes);
        end
        // Keys 0 and 7: key 0 at 36, key 7 at 48.
        keys = 8'h81;
        do_reset();
        run_until(36);
        checks++;
        if (botoes !== 8'h01) begin
            failures++;
            $display("FAIL diff_row_k0 botoes=%h exp=01", botoes);
        end
        tick();
        checks++;
        if (botoes !== 8'h00) begin
            failures++;
            $display("FAIL diff_row_gap botoes=%h exp=00", botoes);
        end
        run_until(48);
        checks++;
        if (botoes !== 8'h80 || estado_botoes !== 8'h81) begin
            failures++;
            $display("FAIL diff_row_k7 botoes=%h estado=%h exp=80/81", botoes, estado_botoes);
        end
    endtask

    // Key 3 (row 1, samples at 8, 24, 40): reset after two pressed samples.
    task automatic test_reset_mid();
        keys = 8'h08;
        do_reset();
        run_until(24);
        do_reset();
        checks++;
        if (estado_botoes !== 8'h00 || botoes !== 8'h00 || linhas_teclado !== 4'b1110) begin
            failures++;
            $display("FAIL mid_reset_clear estado=%h botoes=%h linhas=%b exp=00/00/1110",
                     estado_botoes, botoes, linhas_teclado);
        end
        run_until(39);
        checks++;
        if (bot_or !== 8'h00 || estado_botoes !== 8'h00) begin
            failures++;
            $display("FAIL mid_reset_early bot_or=%h estado=%h exp=00/00", bot_or, estado_botoes);
        end
        tick();
        checks++;
        if (botoes !== 8'h08) begin
            failures++;
            $display("FAIL mid_reset_pulse botoes=%h exp=08", botoes);
        end
        // Reset while a pulse is showing drops it.
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (botoes !== 8'h00 || estado_botoes !== 8'h00) begin
            failures++;
            $display("FAIL mid_pulse_reset botoes=%h estado=%h exp=00/00", botoes, estado_botoes);
        end
        rst  = 1'b0;
        keys = 8'h00;
    endtask

    initial begin
        e      = 0;
        bot_or = 8'h00;
        test_reset();
        test_scan();
        test_hold_and_release();
        test_bounce();
        test_bounce_early();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
